// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
//
// Purpose:
//   Shares one synchronous RAM port between m0 (CPU data master) and m1 (DMA master).
//   Arbitration is round-robin. A master may hold the grant for at most HOLD consecutive
//   cycles while the other master is requesting. Read data returns to the issuing master
//   exactly one cycle after its command is accepted.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   mN_address          master N word address
//   mN_byteenable       master N byte lanes
//   mN_read, mN_write   master N command; read+write together is treated as a write
//   mN_writedata        master N write data
//   mN_waitrequest      high while master N's command is not accepted
//   mN_readdata         master N read data (holds its last value between reads)
//   mN_readdatavalid    master N read data strobe
//   mem_*               RAM s1 port command; mem_readdata is the RAM q output
module onchip_mem_arbiter #(
  parameter int unsigned DEPTH = 5120,
  parameter int unsigned AW    = 13,
  parameter int unsigned HOLD  = 4
) (
  input  logic          clk,
  input  logic          reset_n,

  input  logic [AW-1:0] m0_address,
  input  logic [3:0]    m0_byteenable,
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [31:0]   m0_writedata,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic          m0_readdatavalid,

  input  logic [AW-1:0] m1_address,
  input  logic [3:0]    m1_byteenable,
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [31:0]   m1_writedata,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic          m1_readdatavalid,

  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  output logic          mem_clken,
  input  logic [31:0]   mem_readdata
);

  localparam logic [3:0]  HoldMax = 4'(HOLD);
  localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        state_q, state_d;
  logic [3:0]    hold_q, hold_d;
  logic          last_q, last_d;     // last winner: 0 = m0, 1 = m1
  logic          active_q;           // low until the first clock after reset release

  logic          req0, req1;
  logic          gnt0, gnt1, granted;
  logic [3:0]    hold_inc;

  logic [AW-1:0] addr_q, sel_addr;
  logic [3:0]    be_q, sel_be;
  logic [31:0]   wdata_q, sel_wdata;
  logic          sel_write;
  logic          oor;

  logic          tag_valid_q, tag_owner_q, tag_oor_q;
  logic [31:0]   rdata0_q, rdata1_q, rdata_ret;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign hold_inc = (hold_q < HoldMax) ? hold_q + 4'd1 : HoldMax;

  // Grant and next-state. Nothing is granted until the arbiter has seen a clock out of reset.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (active_q) begin
      unique case (state_q)
        StIdle: begin
          if (req0 && (!req1 || last_q)) gnt0 = 1'b1;
          else if (req1)                 gnt1 = 1'b1;
        end
        StOwn0: begin
          if (req0 && (!req1 || hold_q < HoldMax)) gnt0 = 1'b1;
          else if (req1)                           gnt1 = 1'b1;
        end
        StOwn1: begin
          if (req1 && (!req0 || hold_q < HoldMax)) gnt1 = 1'b1;
          else if (req0)                           gnt0 = 1'b1;
        end
        default: ;
      endcase

      if (gnt0) begin
        state_d = StOwn0;
        last_d  = 1'b0;
        hold_d  = (state_q == StOwn0) ? hold_inc : 4'd1;
      end else if (gnt1) begin
        state_d = StOwn1;
        last_d  = 1'b1;
        hold_d  = (state_q == StOwn1) ? hold_inc : 4'd1;
      end else begin
        state_d = StIdle;
        hold_d  = 4'd0;
      end
    end
  end

  // Command steering; address/data/lanes hold their last value when nobody is granted.
  always_comb begin
    sel_addr  = addr_q;
    sel_be    = be_q;
    sel_wdata = wdata_q;
    sel_write = 1'b0;
    if (gnt0) begin
      sel_addr  = m0_address;
      sel_be    = m0_byteenable;
      sel_wdata = m0_writedata;
      sel_write = m0_write;
    end else if (gnt1) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_write = m1_write;
    end
  end

  assign granted        = gnt0 | gnt1;
  assign oor            = ({1'b0, sel_addr} >= DepthW);
  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;
  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wdata;
  // Out-of-range accesses are accepted but never reach the RAM.
  assign mem_chipselect = granted & ~oor;
  assign mem_write      = granted & sel_write & ~oor;
  assign mem_clken      = active_q;

  // Read return: RAM q is valid the cycle after the address, steered by the tag.
  assign rdata_ret        = tag_oor_q ? 32'h0 : mem_readdata;
  assign m0_readdatavalid = tag_valid_q & ~tag_owner_q;
  assign m1_readdatavalid = tag_valid_q & tag_owner_q;
  assign m0_readdata      = m0_readdatavalid ? rdata_ret : rdata0_q;
  assign m1_readdata      = m1_readdatavalid ? rdata_ret : rdata1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      hold_q      <= 4'd0;
      last_q      <= 1'b1;
      active_q    <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
      tag_oor_q   <= 1'b0;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      active_q    <= 1'b1;
      addr_q      <= sel_addr;
      be_q        <= sel_be;
      wdata_q     <= sel_wdata;
      tag_valid_q <= granted & ~sel_write;
      tag_owner_q <= gnt1;
      tag_oor_q   <= oor;
      rdata0_q    <= m0_readdata;
      rdata1_q    <= m1_readdata;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed testbench for onchip_mem_arbiter with a behavioural 5120x32 RAM behind it.
module tb_onchip_mem_arbiter;

  localparam int AW = 13;

  logic          clk, reset_n;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [31:0]   m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [31:0]   mem_writedata, mem_readdata;

  logic [31:0]   ram [5120];
  int            n_vec = 0;
  int            n_err = 0;

  onchip_mem_arbiter #(.DEPTH(5120), .AW(AW), .HOLD(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: q registers the addressed word on non-write accesses.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect && (mem_address < 13'd5120)) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic clear_all();
    set_m0(1'b0, 1'b0, '0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_all();
    m0_read = 1'b1;
    m1_write = 1'b1;
    step();
    #3;
    n_vec++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_wait0 got %b exp 1", m0_waitrequest); end
    n_vec++; if (m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_wait1 got %b exp 1", m1_waitrequest); end
    n_vec++; if (m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_rdv0 got %b exp 0", m0_readdatavalid); end
    n_vec++; if (m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rst_rdv1 got %b exp 0", m1_readdatavalid); end
    n_vec++; if (m0_readdata !== 32'h0) begin n_err++; $display("FAIL rst_rd0 got %h exp 0", m0_readdata); end
    n_vec++; if (m1_readdata !== 32'h0) begin n_err++; $display("FAIL rst_rd1 got %h exp 0", m1_readdata); end
    n_vec++; if (mem_chipselect !== 1'b0) begin n_err++; $display("FAIL rst_cs got %b exp 0", mem_chipselect); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_we got %b exp 0", mem_write); end
    n_vec++; if (mem_clken !== 1'b0) begin n_err++; $display("FAIL rst_clken got %b exp 0", mem_clken); end
    clear_all();
    reset_n = 1'b1;
    step();
    #3;
    n_vec++; if (mem_clken !== 1'b1) begin n_err++; $display("FAIL rel_clken got %b exp 1", mem_clken); end
    n_vec++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL rel_idle_wait0 got %b exp 1", m0_waitrequest); end
    step();
  endtask

  task automatic test_write_read();
    set_m0(1'b0, 1'b1, 13'h010, 4'hF, 32'hDEADBEEF);
    #3;
    n_vec++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL wr_wait0 got %b exp 0", m0_waitrequest); end
    n_vec++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL wr_we got %b exp 1", mem_write); end
    n_vec++; if (mem_address !== 13'h010) begin n_err++; $display("FAIL wr_addr got %h exp 010", mem_address); end
    step();
    set_m0(1'b1, 1'b0, 13'h010, 4'hF, 32'h0);
    #3;
    n_vec++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL rd_wait0 got %b exp 0", m0_waitrequest); end
    n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rd_we got %b exp 0", mem_write); end
    step();
    clear_all();
    #3;
    n_vec++; if (m0_readdatavalid !== 1'b1) begin n_err++; $display("FAIL rd_rdv0 got %b exp 1", m0_readdatavalid); end
    n_vec++; if (m0_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data0 got %h exp deadbeef", m0_readdata); end
    n_vec++; if (m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_rdv1 got %b exp 0", m1_readdatavalid); end
    step();
    #3;
    n_vec++; if (m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_rdv0_drop got %b exp 0", m0_readdatavalid); end
    n_vec++; if (m0_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold0 got %h exp deadbeef", m0_readdata); end
    step();
  endtask

  task automatic test_round_robin();
    logic exp0, prev0;
    ram[13'h020] = 32'hA0A0A0A0;
    // m1 write makes m1 the last winner, so m0 wins the first contested cycle.
    set_m1(1'b0, 1'b1, 13'h030, 4'hF, 32'hB0B0B0B0);
    #3;
    n_vec++; if (m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL rr_m1wr_wait got %b exp 0", m1_waitrequest); end
    step();
    clear_all();
    step();
    set_m0(1'b1, 1'b0, 13'h020, 4'hF, 32'h0);
    set_m1(1'b1, 1'b0, 13'h030, 4'hF, 32'h0);
    prev0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp0 = ((i / 4) % 2) == 0;
      #3;
      n_vec++;
      if (m0_waitrequest !== !exp0 || m1_waitrequest !== exp0) begin
        n_err++;
        $display("FAIL rr_grant cyc %0d got w0=%b w1=%b exp w0=%b w1=%b", i, m0_waitrequest,
                 m1_waitrequest, !exp0, exp0);
      end
      n_vec++;
      if (mem_address !== (exp0 ? 13'h020 : 13'h030)) begin
        n_err++; $display("FAIL rr_addr cyc %0d got %h", i, mem_address);
      end
      if (i > 0) begin
        n_vec++;
        if (prev0 ? (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 ||
                     m0_readdata !== 32'hA0A0A0A0)
                  : (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 ||
                     m1_readdata !== 32'hB0B0B0B0)) begin
          n_err++;
          $display("FAIL rr_ret cyc %0d got v0=%b v1=%b d0=%h d1=%h exp owner m%0d", i,
                   m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata, prev0 ? 0 : 1);
        end
      end
      prev0 = exp0;
      step();
    end
    clear_all();
    #3;
    n_vec++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA0A0A0A0 || m1_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL rr_last got v0=%b d0=%h v1=%b exp 1 a0a0a0a0 0", m0_readdatavalid,
               m0_readdata, m1_readdatavalid);
    end
    step();
  endtask

  task automatic test_m1_alone();
    set_m1(1'b1, 1'b0, 13'h030, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #3;
      n_vec++;
      if (m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL alone_wait1 cyc %0d got 1 exp 0", i); end
      if (i > 0) begin
        n_vec++;
        if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hB0B0B0B0) begin
          n_err++;
          $display("FAIL alone_ret cyc %0d got v=%b d=%h exp 1 b0b0b0b0", i, m1_readdatavalid,
                   m1_readdata);
        end
      end
      step();
    end
    // m1 has saturated its hold count, so m0 takes over on its first request cycle.
    set_m0(1'b1, 1'b0, 13'h020, 4'hF, 32'h0);
    #3;
    n_vec++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      n_err++;
      $display("FAIL join_grant got w0=%b w1=%b exp 0 1", m0_waitrequest, m1_waitrequest);
    end
    step();
    #3;
    n_vec++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA0A0A0A0 || m1_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL join_ret got v0=%b d0=%h v1=%b exp 1 a0a0a0a0 0", m0_readdatavalid,
               m0_readdata, m1_readdatavalid);
    end
    n_vec++; if (m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL join_hold got w1=%b exp 1", m1_waitrequest); end
    clear_all();
    step();
    step();
  endtask

  task automatic test_out_of_range();
    set_m0(1'b0, 1'b1, 13'd5120, 4'hF, 32'h12345678);
    #3;
    n_vec++;
    if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL oor_wr got w0=%b cs=%b we=%b exp 0 0 0", m0_waitrequest, mem_chipselect,
               mem_write);
    end
    step();
    set_m0(1'b1, 1'b0, 13'd5120, 4'hF, 32'h0);
    #3;
    n_vec++;
    if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b0) begin
      n_err++; $display("FAIL oor_rd got w0=%b cs=%b exp 0 0", m0_waitrequest, mem_chipselect);
    end
    step();
    clear_all();
    #3;
    n_vec++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0) begin
      n_err++;
      $display("FAIL oor_ret got v=%b d=%h exp 1 00000000", m0_readdatavalid, m0_readdata);
    end
    step();
  endtask

  task automatic test_byte_write();
    ram[13'h040] = 32'h11223344;
    set_m0(1'b0, 1'b1, 13'h040, 4'h2, 32'h0000AB00);
    step();
    set_m0(1'b1, 1'b0, 13'h040, 4'hF, 32'h0);
    step();
    clear_all();
    #3;
    n_vec++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1122AB44) begin
      n_err++;
      $display("FAIL byte_ret got v=%b d=%h exp 1 1122ab44", m0_readdatavalid, m0_readdata);
    end
    n_vec++; if (ram[13'h040] !== 32'h1122AB44) begin n_err++; $display("FAIL byte_ram got %h exp 1122ab44", ram[13'h040]); end
    step();
  endtask

  task automatic test_reset_mid_read();
    set_m1(1'b1, 1'b0, 13'h030, 4'hF, 32'h0);
    #3;
    n_vec++; if (m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL mid_wait1 got %b exp 0", m1_waitrequest); end
    step();
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0 || m1_waitrequest !== 1'b1 ||
        mem_clken !== 1'b0 || mem_chipselect !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst got v1=%b d1=%h w1=%b clken=%b cs=%b exp 0 0 1 0 0",
               m1_readdatavalid, m1_readdata, m1_waitrequest, mem_clken, mem_chipselect);
    end
    clear_all();
    step();
    reset_n = 1'b1;
    step();
    #3;
    n_vec++;
    if (m1_readdatavalid !== 1'b0 || mem_clken !== 1'b1) begin
      n_err++; $display("FAIL mid_rel got v1=%b clken=%b exp 0 1", m1_readdatavalid, mem_clken);
    end
    step();
    #3;
    n_vec++; if (m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL mid_rel2 got v1=%b exp 0", m1_readdatavalid); end
    set_m0(1'b1, 1'b0, 13'h020, 4'hF, 32'h0);
    #1;
    n_vec++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL mid_m0_wait got %b exp 0", m0_waitrequest); end
    step();
    clear_all();
    #3;
    n_vec++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hA0A0A0A0 || m1_readdatavalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_m0_ret got v0=%b d0=%h v1=%b exp 1 a0a0a0a0 0", m0_readdatavalid,
               m0_readdata, m1_readdatavalid);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 5120; i++) ram[i] = 32'h0;
    mem_readdata = 32'h0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_m1_alone();
    test_out_of_range();
    test_byte_write();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-port Avalon-MM arbiter that shares the single-port 5120x32 on-chip RAM between two masters (m0: Nios II data master, m1: DMA/peripheral master).
- Sits between the interconnect and the RAM's s1 port and drives the RAM address, byteenable, chipselect, write, writedata and clken signals.
- Round-robin arbitration with a bounded hold window; read data is steered back to the issuing master one cycle later.

Parameters:
- DEPTH, 5120, number of valid RAM words; addresses >= DEPTH are out-of-range.
- AW, 13, address width in words.
- HOLD, 4, max consecutive grants to one master while the other is requesting (1..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- mN_address  in  AW  master N word address (N = 0, 1).
- mN_byteenable  in  4  master N byte lanes.
- mN_read  in  1  master N read request.
- mN_write  in  1  master N write request.
- mN_writedata  in  32  master N write data.
- mN_waitrequest  out  1  master N stall; high means command not accepted.
- mN_readdata  out  32  master N read data.
- mN_readdatavalid  out  1  master N read data valid.
- mem_address  out  AW  RAM address.
- mem_byteenable  out  4  RAM byte lanes.
- mem_chipselect  out  1  RAM chipselect.
- mem_write  out  1  RAM write.
- mem_writedata  out  32  RAM write data.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  32  RAM q; valid the cycle after the address is presented.

Behaviour:
- Reset (reset_n low, async): state IDLE, last_winner=1 (m0 wins first), hold_cnt=0, mN_readdatavalid=0, mN_readdata=0, mem_chipselect=0, mem_write=0, mem_clken=0, mN_waitrequest=1. After release: mem_clken=1, and waitrequest follows arbitration.
- Request: reqN = mN_read | mN_write. read and write both high on one master is treated as a write.
- FSM states: IDLE, OWN0, OWN1. The grant is computed combinationally from the state, the requests and hold_cnt; the state and counter register on clk.
  - IDLE: if only one master requests, it wins. If both request, the master != last_winner wins. Go to OWNx and set hold_cnt=1.
  - OWNx, reqx high, other idle: x keeps the grant and hold_cnt saturates at HOLD.
  - OWNx, reqx high, other requesting, hold_cnt < HOLD: x keeps the grant and hold_cnt increments.
  - OWNx, reqx high, other requesting, hold_cnt = HOLD: the other master wins and hold_cnt=1.
  - OWNx, reqx low: the other master wins if requesting (hold_cnt=1); otherwise go to IDLE.
  - last_winner updates on every grant.
- Granted master: waitrequest=0 in the same cycle and its command is driven onto mem_*. A non-granted requester sees waitrequest=1 and must hold its command stable.
- Out-of-range (address >= DEPTH):
  - Write: accepted (waitrequest=0) but mem_chipselect=0 and mem_write=0, so the RAM is not modified.
  - Read: accepted; readdata=0 is returned with normal latency.
- Read latency: exactly 1 cycle. A registered tag (valid, owner, oor) captures each accepted read. Next cycle: mOwner_readdatavalid=1 and mOwner_readdata = oor ? 0 : mem_readdata. The other master's readdatavalid stays 0 and its readdata holds its previous value.
- Back-to-back reads, including alternating masters, sustain 1 access/cycle. Writes produce no readdatavalid.
- Write then read of the same address in consecutive cycles returns the new data (RAM is single-port, so there is no same-cycle hazard).
- With no grant: mem_chipselect=0 and mem_write=0; mem_address and mem_writedata hold their last value.
- Reset mid-read: the pending tag clears and no readdatavalid is issued after release.

Test Plan:
- After reset, m0 writes 0xDEADBEEF to addr 0x10, then reads addr 0x10 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with data 0xDEADBEEF; m1_readdatavalid stays 0.
- Both masters issue reads every cycle (m0 addr 0x20, m1 addr 0x30), HOLD=4 -> grants follow m0 x4, m1 x4, m0 x4; readdatavalid alternates owners with a 1-cycle lag and no dropped reads.
- m1 requests alone for 10 cycles, then m0 joins -> m1 keeps the grant only until hold_cnt=HOLD; m0 is granted within 4 cycles of asserting its request.
- m0 writes 0x12345678 to addr 5120, then reads addr 5120 -> mem_chipselect stays 0; m0_readdata=0x00000000 with readdatavalid after 1 cycle.
- Byte write with byteenable=0x2 and data 0x0000AB00 over a word holding 0x11223344, then a read -> returns 0x1122AB44.
- reset_n asserted the cycle after an accepted m1 read -> outputs hit reset values immediately; no m1_readdatavalid after release; a subsequent m0 read completes normally.
